// File: rtl/vga_text_render.sv
// vga_text_render: text-mode pixel stage behind the VGA timing generator.
// Looks up character cells and glyph rows and emits a 4-bit palette index.
// Counters, syncs and the active flag all reach the outputs 4 clocks later.
// Optional blinking underline cursor: define VGA_TEXT_CURSOR_EN.
module vga_text_render #(
    parameter int COLS        = 150,
    parameter int ROWS        = 56,
    parameter int CHAR_ADDR_W = 14,
    parameter int FONT_ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [10:0]            h_counter,
    input  logic [9:0]             v_counter,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   can_color_in,
    output logic [CHAR_ADDR_W-1:0] char_addr,
    input  logic [15:0]            char_data,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [7:0]             font_data,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [7:0]             cursor_col,
    input  logic [5:0]             cursor_row,
    input  logic                   cursor_on,
`endif
    output logic                   hsync,
    output logic                   vsync,
    output logic                   can_color,
    output logic [3:0]             pix_color
);

    localparam logic [5:0] LP_ROWS = 6'(ROWS);

    logic [7:0]             w_col;
    logic [5:0]             w_row;
    logic [3:0]             w_glyph;
    logic [2:0]             w_hbit;
    logic                   w_row_ok;
    logic                   w_cursor_hit;
    logic                   w_pixel_bit;
    logic [CHAR_ADDR_W-1:0] w_char_addr;

    assign w_col    = h_counter[10:3];
    assign w_row    = v_counter[9:4];
    assign w_glyph  = v_counter[3:0];
    assign w_hbit   = h_counter[2:0];
    // Row 56 is the partial bottom row and is always blanked.
    assign w_row_ok = (w_row < LP_ROWS);
    // Off-screen positions may exceed the RAM size; truncation is harmless
    // because those pixels are blanked.
    assign w_char_addr = CHAR_ADDR_W'(32'(w_row) * 32'(COLS) + 32'(w_col));

`ifdef VGA_TEXT_CURSOR_EN
    logic [5:0] r_blink_cnt;
    logic       r_vs_prev;

    // Frame counter for cursor blink, advanced on each vsync rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_vs_prev   <= 1'b0;
        end else begin
            r_vs_prev <= vsync_in;
            if (en && vsync_in && !r_vs_prev)
                r_blink_cnt <= r_blink_cnt + 6'd1;
        end
    end

    // Cursor is an underline on glyph rows 14 and 15 of the matching cell.
    assign w_cursor_hit = cursor_on && !r_blink_cnt[5] &&
                          (w_col == cursor_col) && (w_row == cursor_row) &&
                          (w_glyph[3:1] == 3'b111);
`else
    logic w_unused;
    assign w_unused     = en;
    assign w_cursor_hit = 1'b0;
`endif

    // Stage 0 -> 1: register the character address and forward position info.
    logic [3:0] r_glyph_d1;
    logic [2:0] r_hbit_d1;
    logic       r_rowok_d1, r_cur_d1, r_hs_d1, r_vs_d1, r_cc_d1;
    logic [CHAR_ADDR_W-1:0] r_char_addr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_char_addr <= '0;
            r_glyph_d1  <= '0;
            r_hbit_d1   <= '0;
            r_rowok_d1  <= 1'b0;
            r_cur_d1    <= 1'b0;
            r_hs_d1     <= 1'b1;
            r_vs_d1     <= 1'b0;
            r_cc_d1     <= 1'b0;
        end else begin
            r_char_addr <= w_char_addr;
            r_glyph_d1  <= w_glyph;
            r_hbit_d1   <= w_hbit;
            r_rowok_d1  <= w_row_ok;
            r_cur_d1    <= w_cursor_hit;
            r_hs_d1     <= hsync_in;
            r_vs_d1     <= vsync_in;
            r_cc_d1     <= can_color_in;
        end
    end

    // Stage 1 -> 2: cell data valid; build font address, capture colours.
    logic [3:0] r_fg_d2, r_bg_d2;
    logic [2:0] r_hbit_d2;
    logic       r_rowok_d2, r_cur_d2, r_hs_d2, r_vs_d2, r_cc_d2;
    logic [FONT_ADDR_W-1:0] r_font_addr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_font_addr <= '0;
            r_fg_d2     <= '0;
            r_bg_d2     <= '0;
            r_hbit_d2   <= '0;
            r_rowok_d2  <= 1'b0;
            r_cur_d2    <= 1'b0;
            r_hs_d2     <= 1'b1;
            r_vs_d2     <= 1'b0;
            r_cc_d2     <= 1'b0;
        end else begin
            r_font_addr <= FONT_ADDR_W'({char_data[7:0], r_glyph_d1});
            r_fg_d2     <= char_data[11:8];
            r_bg_d2     <= char_data[15:12];
            r_hbit_d2   <= r_hbit_d1;
            r_rowok_d2  <= r_rowok_d1;
            r_cur_d2    <= r_cur_d1;
            r_hs_d2     <= r_hs_d1;
            r_vs_d2     <= r_vs_d1;
            r_cc_d2     <= r_cc_d1;
        end
    end

    assign w_pixel_bit = font_data[3'd7 - r_hbit_d2] | r_cur_d2;

    // Stage 2 -> 3: glyph row valid; select the pixel bit.
    logic [3:0] r_fg_d3, r_bg_d3;
    logic       r_pix_d3, r_rowok_d3, r_hs_d3, r_vs_d3, r_cc_d3;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_d3   <= 1'b0;
            r_fg_d3    <= '0;
            r_bg_d3    <= '0;
            r_rowok_d3 <= 1'b0;
            r_hs_d3    <= 1'b1;
            r_vs_d3    <= 1'b0;
            r_cc_d3    <= 1'b0;
        end else begin
            r_pix_d3   <= w_pixel_bit;
            r_fg_d3    <= r_fg_d2;
            r_bg_d3    <= r_bg_d2;
            r_rowok_d3 <= r_rowok_d2;
            r_hs_d3    <= r_hs_d2;
            r_vs_d3    <= r_vs_d2;
            r_cc_d3    <= r_cc_d2;
        end
    end

    // Stage 3: output register with blanking.
    logic [3:0] r_pix_color;
    logic       r_hsync, r_vsync, r_can_color;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_color <= '0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b0;
            r_can_color <= 1'b0;
        end else begin
            r_pix_color <= (r_cc_d3 && r_rowok_d3) ? (r_pix_d3 ? r_fg_d3 : r_bg_d3) : 4'h0;
            r_hsync     <= r_hs_d3;
            r_vsync     <= r_vs_d3;
            r_can_color <= r_cc_d3;
        end
    end

    assign char_addr = r_char_addr;
    assign font_addr = r_font_addr;
    assign pix_color = r_pix_color;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign can_color = r_can_color;

endmodule

// File: tb/tb_vga_text_render.sv
// Scoreboard bench for vga_text_render: stimulus pushes expectations,
// a negedge monitor pops them at +1 (char_addr), +2 (font_addr), +4 (outputs).
`timescale 1ns/1ps
module tb_vga_text_render;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [10:0] h_counter = '0;
    logic [9:0]  v_counter = '0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b0;
    logic        can_color_in = 1'b0;
    logic [13:0] char_addr;
    logic [15:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        hsync, vsync, can_color;
    logic [3:0]  pix_color;
`ifdef VGA_TEXT_CURSOR_EN
    logic [7:0]  cursor_col = 8'd2;
    logic [5:0]  cursor_row = 6'd3;
    logic        cursor_on  = 1'b1;
`endif

    always #5 clk = ~clk;

    logic [15:0] cram [0:16383];
    logic [7:0]  fram [0:4095];
    assign char_data = cram[char_addr];
    assign font_data = fram[font_addr];

    vga_text_render #(.COLS(150), .ROWS(56), .CHAR_ADDR_W(14), .FONT_ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .en(en),
        .h_counter(h_counter), .v_counter(v_counter),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .can_color_in(can_color_in),
        .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data),
`ifdef VGA_TEXT_CURSOR_EN
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_on(cursor_on),
`endif
        .hsync(hsync), .vsync(vsync), .can_color(can_color), .pix_color(pix_color)
    );

    typedef struct {
        int          id;
        logic        chk_ca;
        logic [13:0] ca;
        logic        chk_fa;
        logic [11:0] fa;
        logic [3:0]  pix;
        logic        hs;
        logic        vs;
        logic        cc;
    } exp_t;

    exp_t q_ca[$];
    exp_t q_fa[$];
    exp_t q_out[$];

    int   n_vec  = 0;
    int   n_miss = 0;
    int   id_cnt = 0;
    logic vec_valid = 1'b0;
    logic chk_rst   = 1'b0;
    logic chk_hold  = 1'b0;
    logic chk_drain = 1'b0;
    logic tag1 = 1'b0, tag2 = 1'b0, tag3 = 1'b0, tag4 = 1'b0;

    // Tracks when each issued vector's responses are due.
    always @(posedge clk) begin
        tag1 <= vec_valid;
        tag2 <= tag1;
        tag3 <= tag2;
        tag4 <= tag3;
    end

    task automatic cmp(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against scoreboard entries.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_rst) begin
            cmp("rst_hsync", -1, 16'(hsync), 16'd1);
            cmp("rst_vsync", -1, 16'(vsync), 16'd0);
            cmp("rst_can_color", -1, 16'(can_color), 16'd0);
            cmp("rst_pix_color", -1, 16'(pix_color), 16'd0);
            cmp("rst_char_addr", -1, 16'(char_addr), 16'd0);
            cmp("rst_font_addr", -1, 16'(font_addr), 16'd0);
        end
        if (chk_hold) begin
            cmp("hold_hsync", -1, 16'(hsync), 16'd1);
            cmp("hold_vsync", -1, 16'(vsync), 16'd0);
            cmp("hold_can_color", -1, 16'(can_color), 16'd0);
            cmp("hold_pix_color", -1, 16'(pix_color), 16'd0);
        end
        if (tag1) begin
            if (q_ca.size() == 0) cmp("ca_underflow", -1, 16'd1, 16'd0);
            else begin
                e = q_ca.pop_front();
                if (e.chk_ca) cmp("char_addr", e.id, 16'(char_addr), 16'(e.ca));
            end
        end
        if (tag2) begin
            if (q_fa.size() == 0) cmp("fa_underflow", -1, 16'd1, 16'd0);
            else begin
                e = q_fa.pop_front();
                if (e.chk_fa) cmp("font_addr", e.id, 16'(font_addr), 16'(e.fa));
            end
        end
        if (tag4) begin
            if (q_out.size() == 0) cmp("out_underflow", -1, 16'd1, 16'd0);
            else begin
                e = q_out.pop_front();
                cmp("pix_color", e.id, 16'(pix_color), 16'(e.pix));
                cmp("hsync", e.id, 16'(hsync), 16'(e.hs));
                cmp("vsync", e.id, 16'(vsync), 16'(e.vs));
                cmp("can_color", e.id, 16'(can_color), 16'(e.cc));
            end
        end
        if (chk_drain) begin
            cmp("drain_q_ca", -1, 16'(q_ca.size()), 16'd0);
            cmp("drain_q_fa", -1, 16'(q_fa.size()), 16'd0);
            cmp("drain_q_out", -1, 16'(q_out.size()), 16'd0);
        end
    end

    task automatic apply(input logic [10:0] h, input logic [9:0] v,
                         input logic hs, input logic vs, input logic cc,
                         input logic cca, input logic [13:0] ca,
                         input logic cfa, input logic [11:0] fa,
                         input logic [3:0] pix);
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b0; chk_rst = 1'b0; chk_hold = 1'b0; chk_drain = 1'b0;
        h_counter = h; v_counter = v;
        hsync_in = hs; vsync_in = vs; can_color_in = cc;
        vec_valid = 1'b1;
        e.id = id_cnt; id_cnt++;
        e.chk_ca = cca; e.ca = ca; e.chk_fa = cfa; e.fa = fa;
        e.pix = pix; e.hs = hs; e.vs = vs; e.cc = cc;
        q_ca.push_back(e);
        q_fa.push_back(e);
        q_out.push_back(e);
    endtask

    task automatic drive_raw(input logic r, input logic [10:0] h, input logic [9:0] v,
                             input logic hs, input logic vs, input logic cc);
        @(posedge clk); #1;
        rst = r; chk_rst = 1'b0; chk_hold = 1'b0; chk_drain = 1'b0;
        vec_valid = 1'b0;
        h_counter = h; v_counter = v;
        hsync_in = hs; vsync_in = vs; can_color_in = cc;
    endtask

    logic [3:0] gp [0:7];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        for (int i = 0; i < 16384; i++) cram[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) fram[i] = 8'h00;
        cram[0]    = 16'h1F41; fram[12'h410] = 8'hA5;
        cram[151]  = 16'h2302; fram[12'h020] = 8'h80;
        cram[8399] = 16'h5A7E; fram[12'h7EF] = 8'h01;
        cram[8402] = 16'hFF11; fram[12'h111] = 8'hFF;
        cram[162]  = 16'h7700;
        cram[452]  = 16'h5C00;
        gp[0] = 4'hF; gp[1] = 4'h1; gp[2] = 4'hF; gp[3] = 4'h1;
        gp[4] = 4'h1; gp[5] = 4'hF; gp[6] = 4'h1; gp[7] = 4'hF;

        // Power-on reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            drive_raw(1'b1, 11'($urandom_range(0, 1903)), 10'($urandom_range(0, 931)),
                      1'($urandom), 1'($urandom), 1'($urandom));
            chk_rst = 1'b1;
        end

        // Glyph row 0 of cell 0; first 4 cycles outputs must still be at reset.
        for (int i = 0; i < 8; i++) begin
            apply(11'(i), 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 14'd0, 1'b1, 12'h410, gp[i]);
            chk_hold = (i < 4);
        end

        // Address arithmetic.
        apply(11'd8,    10'd16,  1'b1, 1'b0, 1'b1, 1'b1, 14'd151,  1'b1, 12'h020, 4'h3);
        apply(11'd9,    10'd16,  1'b1, 1'b0, 1'b1, 1'b1, 14'd151,  1'b1, 12'h020, 4'h2);
        apply(11'd1199, 10'd895, 1'b1, 1'b0, 1'b1, 1'b1, 14'd8399, 1'b1, 12'h7EF, 4'hA);
        apply(11'd1192, 10'd895, 1'b1, 1'b0, 1'b1, 1'b1, 14'd8399, 1'b1, 12'h7EF, 4'h5);

        // Blanking: partial bottom row, inactive flag, far off-screen.
        apply(11'd16,   10'd897, 1'b1, 1'b0, 1'b1, 1'b1, 14'd8402, 1'b1, 12'h111, 4'h0);
        apply(11'd1300, 10'd0,   1'b1, 1'b0, 1'b0, 1'b1, 14'd162,  1'b1, 12'h000, 4'h0);
        apply(11'd1903, 10'd931, 1'b1, 1'b0, 1'b0, 1'b1, 14'd8937, 1'b1, 12'h003, 4'h0);

        // Sync alignment through the pipeline.
        apply(11'd1248, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 14'd156, 1'b0, 12'h000, 4'h0);
        apply(11'd1248, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 14'd156, 1'b0, 12'h000, 4'h0);
        apply(11'd1248, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 14'd156, 1'b0, 12'h000, 4'h0);
        apply(11'd1248, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 14'd156, 1'b0, 12'h000, 4'h0);
        apply(11'd1248, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 14'd156, 1'b0, 12'h000, 4'h0);
        apply(11'd1248, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 14'd156, 1'b0, 12'h000, 4'h0);
        apply(11'd1248, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 14'd156, 1'b0, 12'h000, 4'h0);

`ifdef VGA_TEXT_CURSOR_EN
        apply(11'd16, 10'd62, 1'b1, 1'b0, 1'b1, 1'b1, 14'd452, 1'b1, 12'h00E, 4'hC);
        apply(11'd23, 10'd63, 1'b1, 1'b0, 1'b1, 1'b1, 14'd452, 1'b1, 12'h00F, 4'hC);
        apply(11'd16, 10'd61, 1'b1, 1'b0, 1'b1, 1'b1, 14'd452, 1'b1, 12'h00D, 4'h5);
        apply(11'd24, 10'd62, 1'b1, 1'b0, 1'b1, 1'b1, 14'd453, 1'b1, 12'h00E, 4'h0);
`endif

        // Drain, then fill pipeline with an active pixel and reset mid-line.
        for (int i = 0; i < 5; i++) drive_raw(1'b0, 11'd1500, 10'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_raw(1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        drive_raw(1'b1, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        drive_raw(1'b1, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        chk_rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply(11'(i), 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 14'd0, 1'b1, 12'h410, gp[i]);
            chk_hold = (i < 4);
        end

        for (int i = 0; i < 6; i++) drive_raw(1'b0, 11'd1500, 10'd0, 1'b1, 1'b0, 1'b0);
        chk_drain = 1'b1;
        drive_raw(1'b0, 11'd1500, 10'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Text-mode pixel stage directly downstream of the VGA timing generator.
- Consumes raw h/v counters, syncs and the active-video flag.
- Fetches character cells from an external character RAM and glyph rows from an external font ROM.
- Emits a 4-bit palette index per pixel, with syncs delayed to stay aligned with the pipeline.
- Active area is 1200x900 px, using 8x16 glyphs, giving a 150x56 cell grid. The last 4 scanlines are a partial row and are blanked.

Parameters:
- COLS, 150, character cells per row.
- ROWS, 56, full character rows displayed.
- CHAR_ADDR_W, 14, character RAM address width (COLS*ROWS must be < 2**CHAR_ADDR_W).
- FONT_ADDR_W, 12, font ROM address width (256 glyphs x 16 rows).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  block enable, same signal that drives the timing generator
- h_counter  in  11  horizontal position, 0-1903
- v_counter  in  10  vertical position, 0-931
- hsync_in  in  1  hsync from timing generator, active-low
- vsync_in  in  1  vsync from timing generator, active-high
- can_color_in  in  1  active-video flag
- char_addr  out  CHAR_ADDR_W  character RAM read address
- char_data  in  16  cell data, 1-cycle synchronous read: [7:0] code, [11:8] fg, [15:12] bg
- font_addr  out  FONT_ADDR_W  font ROM read address, {code, glyph_row[3:0]}
- font_data  in  8  glyph row, 1-cycle synchronous read; bit 7 = leftmost pixel
- hsync  out  1  hsync delayed 4 cycles
- vsync  out  1  vsync delayed 4 cycles
- can_color  out  1  active flag delayed 4 cycles
- pix_color  out  4  palette index

Behaviour:
- Fixed latency of 4 clk from the counter/sync inputs to the matching outputs. Every input-derived value travels through a 4-deep shift pipeline; there is no stalling or backpressure.
- S0 (cycle 0): col = h_counter[10:3], row = v_counter[9:4], glyph_row = v_counter[3:0].
  - char_addr <= row*COLS + col, registered.
  - col, row, glyph_row and h_counter[2:0] are forwarded down the pipeline.
- S1: char_data is valid. font_addr <= {char_data[7:0], glyph_row}, registered. fg and bg are captured.
- S2: font_data is valid. pixel_bit = font_data[7 - hbit]. fg/bg are forwarded.
- S3 (output register): pix_color <= (can_color_d3 && row_d3 < ROWS) ? (pixel_bit ? fg : bg) : 0.
- Blanking:
  - can_color low means pix_color = 0 regardless of fetched data.
  - v_counter 896-899 (row 56) gives pix_color = 0.
  - Fetches outside the active area are don't-care but must not produce X on outputs.
- Address arithmetic: row*COLS uses a constant multiply. Values beyond active, e.g. h = 1903 giving col 237, may overflow CHAR_ADDR_W; truncate silently, since they are always blanked.
- Reset (rst high): all pipeline registers clear.
  - Outputs: hsync = 1 (inactive), vsync = 0, can_color = 0, pix_color = 0, char_addr = 0, font_addr = 0.
  - Reset has priority over en.
  - Reset mid-line: outputs are at reset values on the cycle after rst is sampled high. After release, the first valid output appears 4 cycles later; the outputs at pipeline stages not yet refilled keep their reset (inactive) values.
- en low: the pipeline keeps shifting. The upstream counters are held at 0, so the outputs settle to the (0,0) pixel state after 4 cycles. There is no special handling.

Optional Feature:
- Macro: VGA_TEXT_CURSOR_EN.
- Defined adds inputs:
  - cursor_col[7:0]
  - cursor_row[5:0]
  - cursor_on (1)
- Defined adds 6-bit frame counter blink_cnt:
  - Cleared by rst.
  - Increments on each vsync_in 0->1 edge while en = 1; wraps 63->0.
- Defined cursor rendering: when cursor_on && blink_cnt[5] == 0 && cell == cursor && glyph_row in {14,15}, the pixel is forced to fg. Latency is unchanged at 4.
- Undefined: no cursor ports, no counter, behaviour exactly as above.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> hsync = 1, vsync = 0, can_color = 0, pix_color = 0, char_addr = 0, font_addr = 0.
- Glyph render: h = 0..7, v = 0, can_color_in = 1, RAM[0] = 0x1F41, font[0x410] = 0xA5 -> char_addr = 0 at cycle 1, font_addr = 0x410 at cycle 2, pix_color sequence F,1,F,1,1,F,1,F starting at cycle 4.
- Address: h = 8, v = 16 -> char_addr = 151; h = 1199, v = 895 -> char_addr = 8399, font_addr low nibble = 0xF.
- Blanking: v = 897 with active data, or can_color_in = 0 at h = 1300 -> pix_color = 0.
- Sync delay: hsync_in falls at cycle N, vsync_in rises at cycle M -> hsync falls at N+4, vsync rises at M+4. can_color tracks can_color_in +4.
- Cursor (macro defined): cursor at (2,3), cursor_on = 1, blink_cnt = 0, glyph byte 0x00, fg = 0xC -> pix_color = C at v = 62,63 for h = 16..23. After 32 vsync edges -> bg.
